// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for four external ALU units: latches one command, pulses the
// selected unit enable, waits for its result flag (with timeout), and holds the result for the consumer.
module alu_cmd_sequencer #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_fn,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [1:0]        alu_fn,
  output logic              arith_enable,
  output logic              logic_enable,
  output logic              cmp_enable,
  output logic              shift_enable,
  input  logic [DATA_W-1:0] arith_out,
  input  logic [DATA_W-1:0] logic_out,
  input  logic [DATA_W-1:0] cmp_out,
  input  logic [DATA_W-1:0] shift_out,
  input  logic              arith_flag,
  input  logic              logic_flag,
  input  logic              cmp_flag,
  input  logic              shift_flag,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_eq,
  output logic              res_gt,
  output logic              res_lt,
  output logic              res_err,
  output logic [7:0]        op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [1:0]        sel;
  logic [3:0]        wait_cnt;
  logic              accept, hit, tmo, hs;
  logic              sel_flag;
  logic [DATA_W-1:0] sel_out;
  logic [3:0]        en_vec;

  // Only the selected unit's flag/result is ever looked at.
  always_comb begin
    sel_flag = 1'b0;
    sel_out  = '0;
    unique case (sel)
      2'b00: begin sel_flag = arith_flag; sel_out = arith_out; end
      2'b01: begin sel_flag = logic_flag; sel_out = logic_out; end
      2'b10: begin sel_flag = cmp_flag;   sel_out = cmp_out;   end
      2'b11: begin sel_flag = shift_flag; sel_out = shift_out; end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    hit      = 1'b0;
    tmo      = 1'b0;
    hs       = 1'b0;
    en_vec   = '0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept   = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        en_vec   = 4'b0001 << sel;
        state_nx = WAIT;
      end
      WAIT: begin
        // A flag arriving in the final allowed cycle wins over the timeout.
        if (sel_flag) begin
          hit      = 1'b1;
          state_nx = DONE;
        end else if (wait_cnt == TMO_LAST) begin
          tmo      = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          hs       = 1'b1;
          state_nx = IDLE;
        end
      end
    endcase
  end

  assign cmd_ready    = (state == IDLE);
  assign res_valid    = (state == DONE);
  assign arith_enable = en_vec[0];
  assign logic_enable = en_vec[1];
  assign cmp_enable   = en_vec[2];
  assign shift_enable = en_vec[3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      A        <= '0;
      B        <= '0;
      alu_fn   <= '0;
      sel      <= '0;
      wait_cnt <= '0;
      res_data <= '0;
      res_eq   <= 1'b0;
      res_gt   <= 1'b0;
      res_lt   <= 1'b0;
      res_err  <= 1'b0;
      op_count <= '0;
    end else begin
      if (accept) begin
        A      <= cmd_a;
        B      <= cmd_b;
        alu_fn <= cmd_fn[1:0];
        sel    <= cmd_fn[3:2];
      end
      if (state == ISSUE)
        wait_cnt <= '0;
      else if (state == WAIT && !sel_flag)
        wait_cnt <= wait_cnt + 4'd1;
      if (hit) begin
        res_data <= sel_out;
        res_err  <= 1'b0;
        res_eq   <= (sel == 2'b10) && (sel_out == DATA_W'(1));
        res_gt   <= (sel == 2'b10) && (sel_out == DATA_W'(2));
        res_lt   <= (sel == 2'b10) && (sel_out == DATA_W'(3));
      end else if (tmo) begin
        res_data <= '0;
        res_err  <= 1'b1;
        res_eq   <= 1'b0;
        res_gt   <= 1'b0;
        res_lt   <= 1'b0;
      end
      if (hs)
        op_count <= op_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with simple registered unit models
// and per-unit manual flag overrides for timing corner cases.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_fn;
  logic [15:0] cmd_a, cmd_b, A, B;
  logic [1:0]  alu_fn;
  logic        arith_enable, logic_enable, cmp_enable, shift_enable;
  logic [15:0] arith_out, logic_out, cmp_out, shift_out;
  logic        arith_flag, logic_flag, cmp_flag, shift_flag;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic        res_eq, res_gt, res_lt, res_err;
  logic [7:0]  op_count;

  logic [3:0]  resp;
  logic [3:0]  man_flag;
  logic [15:0] man_out;
  logic [3:0]  m_flag = '0;
  logic [15:0] m_out [4];

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_cnt = 8'h00;
  int          lat;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DATA_W(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_fn(cmd_fn),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .A(A), .B(B), .alu_fn(alu_fn),
    .arith_enable(arith_enable), .logic_enable(logic_enable),
    .cmp_enable(cmp_enable), .shift_enable(shift_enable),
    .arith_out(arith_out), .logic_out(logic_out), .cmp_out(cmp_out), .shift_out(shift_out),
    .arith_flag(arith_flag), .logic_flag(logic_flag), .cmp_flag(cmp_flag), .shift_flag(shift_flag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_eq(res_eq), .res_gt(res_gt), .res_lt(res_lt), .res_err(res_err),
    .op_count(op_count)
  );

  // Unit models: result and flag one cycle after the enable pulse.
  always @(posedge clk) begin
    m_flag <= {shift_enable, cmp_enable, logic_enable, arith_enable} & resp;
    if (arith_enable) m_out[0] <= (alu_fn == 2'b01) ? A - B : A + B;
    if (logic_enable)
      case (alu_fn)
        2'b00:   m_out[1] <= A & B;
        2'b01:   m_out[1] <= A | B;
        2'b10:   m_out[1] <= A ^ B;
        default: m_out[1] <= ~A;
      endcase
    if (cmp_enable) m_out[2] <= (A == B) ? 16'd1 : (A > B) ? 16'd2 : 16'd3;
    if (shift_enable)
      m_out[3] <= (alu_fn == 2'b00) ? A << B[3:0] : (alu_fn == 2'b01) ? A >> B[3:0] : A;
  end

  assign arith_flag = m_flag[0] | man_flag[0];
  assign logic_flag = m_flag[1] | man_flag[1];
  assign cmp_flag   = m_flag[2] | man_flag[2];
  assign shift_flag = m_flag[3] | man_flag[3];
  assign arith_out  = man_flag[0] ? man_out : m_out[0];
  assign logic_out  = man_flag[1] ? man_out : m_out[1];
  assign cmp_out    = man_flag[2] ? man_out : m_out[2];
  assign shift_out  = man_flag[3] ? man_out : m_out[3];

  task automatic chkw(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] en_bits();
    return {12'h000, shift_enable, cmp_enable, logic_enable, arith_enable};
  endfunction

  task automatic chk_zero(input string tag);
    chkw({tag, "_A"}, A, 16'h0000);
    chkw({tag, "_B"}, B, 16'h0000);
    chkw({tag, "_fn"}, {14'h0, alu_fn}, 16'h0000);
    chkw({tag, "_data"}, res_data, 16'h0000);
    chkw({tag, "_cnt"}, {8'h00, op_count}, 16'h0000);
    chkw({tag, "_en"}, en_bits(), 16'h0000);
    chkw({tag, "_flags"}, {11'h0, res_valid, res_eq, res_gt, res_lt, res_err}, 16'h0000);
  endtask

  // Caller is at a negedge with the DUT idle; returns at the negedge of the ISSUE cycle.
  task automatic send_cmd(input string tag, input logic [3:0] fn, input logic [15:0] a, input logic [15:0] b);
    logic [3:0] exp_en;
    exp_en    = 4'b0001 << fn[3:2];
    cmd_valid = 1'b1;
    cmd_fn    = fn;
    cmd_a     = a;
    cmd_b     = b;
    chk1({tag, "_ready"}, cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_a     = 16'hFFFF;
    cmd_b     = 16'hFFFF;
    chkw({tag, "_en"}, en_bits(), {12'h000, exp_en});
    chkw({tag, "_A"}, A, a);
    chkw({tag, "_B"}, B, b);
    chkw({tag, "_fn"}, {14'h0, alu_fn}, {14'h0, fn[1:0]});
  endtask

  task automatic wait_valid(input string tag, output int l);
    l = 0;
    for (int i = 2; i <= 24; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        l = i;
        break;
      end
      chkw({tag, "_en_off"}, en_bits(), 16'h0000);
    end
  endtask

  task automatic check_res(input string tag, input logic [15:0] d, input logic eq, input logic gt,
                           input logic lt, input logic err);
    chkw({tag, "_data"}, res_data, d);
    chkw({tag, "_stat"}, {12'h0, res_eq, res_gt, res_lt, res_err}, {12'h0, eq, gt, lt, err});
  endtask

  task automatic handshake(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    exp_cnt++;
    chk1({tag, "_valid_low"}, res_valid, 1'b0);
    chk1({tag, "_ready_back"}, cmd_ready, 1'b1);
    chkw({tag, "_cnt"}, {8'h00, op_count}, {8'h00, exp_cnt});
  endtask

  task automatic run_op(input string tag, input logic [3:0] fn, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] d, input logic eq, input logic gt, input logic lt,
                        input logic err, input int exp_lat);
    send_cmd(tag, fn, a, b);
    wait_valid(tag, lat);
    chkw({tag, "_lat"}, 16'(lat), 16'(exp_lat));
    check_res(tag, d, eq, gt, lt, err);
    handshake(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_fn = 4'h0; cmd_a = '0; cmd_b = '0;
    res_ready = 1'b0; resp = 4'b1111; man_flag = 4'b0000; man_out = '0;

    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    chk1("reset_ready", cmd_ready, 1'b1);

    run_op("cmp_eq",  4'b1001, 16'h0005, 16'h0005, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    run_op("cmp_lt",  4'b1011, 16'h0002, 16'h0007, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b0, 3);
    run_op("add",     4'b0000, 16'h1234, 16'h0101, 16'h1335, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    run_op("sub",     4'b0001, 16'h0010, 16'h0003, 16'h000D, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    run_op("and",     4'b0100, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    run_op("xor",     4'b0110, 16'hFF00, 16'h0FF0, 16'hF0F0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    run_op("shl",     4'b1100, 16'h0003, 16'h0004, 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    run_op("shr_one", 4'b1101, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    run_op("cmp_gt",  4'b1000, 16'h0009, 16'h0003, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0, 3);

    // Unresponsive arith unit: four WAIT cycles then error.
    resp = 4'b1110;
    run_op("timeout", 4'b0001, 16'h1111, 16'h2222, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 6);

    // Flag in the last allowed WAIT cycle; unselected flag earlier is ignored.
    send_cmd("prio", 4'b0000, 16'h0001, 16'h0001);
    man_flag = 4'b0010; man_out = 16'hBEEF;
    repeat (3) begin
      @(negedge clk);
      chk1("prio_wait", res_valid, 1'b0);
    end
    @(negedge clk);
    man_flag = 4'b0001; man_out = 16'h0ABC;
    @(negedge clk);
    man_flag = 4'b0000;
    chk1("prio_valid", res_valid, 1'b1);
    check_res("prio", 16'h0ABC, 1'b0, 1'b0, 1'b0, 1'b0);
    handshake("prio");
    resp = 4'b1111;

    // Compare result outside 1..3 decodes to no status.
    resp = 4'b1011;
    send_cmd("cmp_other", 4'b1010, 16'h0001, 16'h0002);
    @(negedge clk);
    man_flag = 4'b0100; man_out = 16'h0004;
    @(negedge clk);
    man_flag = 4'b0000;
    chk1("cmp_other_valid", res_valid, 1'b1);
    check_res("cmp_other", 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0);
    handshake("cmp_other");
    resp = 4'b1111;

    // Consumer stalls five cycles in DONE while a new command and a stray flag are presented.
    send_cmd("hold", 4'b1100, 16'h0003, 16'h0004);
    wait_valid("hold", lat);
    chkw("hold_lat", 16'(lat), 16'd3);
    cmd_valid = 1'b1; cmd_fn = 4'b0000; cmd_a = 16'h7777; cmd_b = 16'h8888;
    man_flag = 4'b1000; man_out = 16'hDEAD;
    for (int i = 0; i < 5; i++) begin
      chk1("hold_valid", res_valid, 1'b1);
      chkw("hold_data", res_data, 16'h0030);
      chk1("hold_busy", cmd_ready, 1'b0);
      chkw("hold_cnt", {8'h00, op_count}, {8'h00, exp_cnt});
      chkw("hold_A", A, 16'h0003);
      @(negedge clk);
    end
    cmd_valid = 1'b0; man_flag = 4'b0000;
    check_res("hold", 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0);
    handshake("hold");

    // Asynchronous reset in WAIT, then a late flag that must be ignored.
    resp = 4'b1110;
    send_cmd("rst_mid", 4'b0001, 16'h00AA, 16'h0055);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_zero("rst_mid");
    man_flag = 4'b0001; man_out = 16'h1234;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk1("rst_mid_valid", res_valid, 1'b0);
    chk1("rst_mid_ready", cmd_ready, 1'b1);
    chkw("rst_mid_data", res_data, 16'h0000);
    chkw("rst_mid_cnt", {8'h00, op_count}, 16'h0000);
    man_flag = 4'b0000; resp = 4'b1111; exp_cnt = 8'h00;
    run_op("post_rst", 4'b0000, 16'h0007, 16'h0008, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 3);

    // Back-to-back ops (4 cycles each with ready held high) up to the wrap.
    cmd_valid = 1'b1; cmd_fn = 4'b1000; cmd_a = 16'h0004; cmd_b = 16'h0004;
    res_ready = 1'b1;
    repeat (4 * 254) @(negedge clk);
    chkw("cnt_255", {8'h00, op_count}, 16'h00FF);
    repeat (4) @(negedge clk);
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    chkw("cnt_wrap", {8'h00, op_count}, 16'h0000);
    chk1("wrap_ready", cmd_ready, 1'b1);
    check_res("wrap_last", 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter DATA_W, default 16: operand and result width.
REQ-002 Parameter TIMEOUT, default 4, legal 1..15: WAIT cycles allowed before error.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  sequencer accepts a command this cycle.
REQ-007 cmd_fn  input  4  [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift); [1:0] unit function.
REQ-008 cmd_a, cmd_b  input  DATA_W  operands.
REQ-009 A, B  output  DATA_W  registered operands to units.
REQ-010 alu_fn  output  2  registered unit function code.
REQ-011 arith_enable, logic_enable, cmp_enable, shift_enable  output  1 each  unit enables.
REQ-012 arith_out, logic_out, cmp_out, shift_out  input  DATA_W each  unit results.
REQ-013 arith_flag, logic_flag, cmp_flag, shift_flag  input  1 each  unit result-valid flags.
REQ-014 res_valid  output  1  result available.
REQ-015 res_ready  input  1  consumer accepts result.
REQ-016 res_data  output  DATA_W  captured unit result.
REQ-017 res_eq, res_gt, res_lt  output  1 each  decoded compare status.
REQ-018 res_err  output  1  operation timed out.
REQ-019 op_count  output  8  completed (accepted) results, wraps 255->0.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT, DONE; only IDLE asserts cmd_ready.
REQ-021 IDLE: on cmd_valid=1, register cmd_a->A, cmd_b->B, cmd_fn[1:0]->alu_fn, cmd_fn[3:2]->internal select; go ISSUE.
REQ-022 A, B, alu_fn SHALL remain stable from ISSUE until return to IDLE.
REQ-023 ISSUE: exactly the selected enable high for one cycle, all others low; go WAIT; clear timeout counter.
REQ-024 Enables SHALL be low in IDLE, WAIT, DONE; at most one enable high in any cycle.
REQ-025 WAIT: selected unit's flag=1 -> capture its out into res_data, res_err=0, go DONE.
REQ-026 WAIT: flags of unselected units and any flag outside WAIT SHALL be ignored.
REQ-027 WAIT: counter increments per cycle without flag; on reaching TIMEOUT without flag -> res_data=0, res_eq/gt/lt=0, res_err=1, go DONE.
REQ-028 Flag in the same cycle the counter reaches TIMEOUT SHALL take priority (normal result, no error).
REQ-029 Compare decode (select=10 only): res_eq=(cmp_out==1), res_gt=(cmp_out==2), res_lt=(cmp_out==3); any other value -> all three 0; non-compare ops -> all three 0.
REQ-030 DONE: res_valid=1; res_data, flags, res_err held stable until res_valid&res_ready.
REQ-031 On res_valid&res_ready: go IDLE, res_valid=0 next cycle, op_count+1 (mod 256, errored ops included).
REQ-032 Latency: command accepted at edge k -> enable high cycle k+1 -> unit flag cycle k+2 -> res_valid from cycle k+3 (responsive unit).
REQ-033 No overlap: next command accepted no earlier than the cycle after result handshake.

Reset
REQ-034 rst=0 SHALL immediately force IDLE; A, B, alu_fn, res_data, op_count, counter =0; all enables, res_valid, res_eq/gt/lt, res_err =0; cmd_ready=1 after release.
REQ-035 Reset mid-operation (ISSUE/WAIT/DONE) SHALL discard the operation without updating op_count.

Verification
REQ-036 cmd_fn=4'b1001, A=B=16'h0005, cmp unit model -> cmp_enable one cycle, res_valid 3 cycles after accept, res_data=1, res_eq=1.
REQ-037 cmd_fn=4'b1011, A=16'h0002, B=16'h0007 -> res_data=3, res_lt=1, res_eq=res_gt=0.
REQ-038 cmd_fn=4'b0001, arith unit never flags, TIMEOUT=4 -> res_err=1, res_data=0 after 4 WAIT cycles.
REQ-039 res_ready held low 5 cycles in DONE -> res_data/flags stable, cmd_ready=0, op_count unchanged until handshake.
REQ-040 rst pulsed low during WAIT -> all outputs 0 asynchronously, late unit flag ignored, next command completes normally.
REQ-041 256 back-to-back completed ops -> op_count wraps to 0.
